adder_sequencer: RTL and testbench
==================================

ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32, operand/bus data width.
- ADDR_WIDTH, default 8, AXI-Lite address width.
- BASE_ADDR, default 0, adder register base.
- TIMEOUT, default 255, maximum wait cycles per handshake.
REQ-002 Ports SHALL be:
- m1_axi_aclk  in  1  sole clock, all logic on rising edge.
- m1_axi_aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  request to run one addition.
- cmd_ready  out  1  sequencer idle and able to accept a command.
- cmd_opa  in  DATA_WIDTH  operand A.
- cmd_opb  in  DATA_WIDTH  operand B.
- rsp_done  out  1  one-cycle pulse marking completion.
- rsp_result  out  DATA_WIDTH  sum read back.
- rsp_overflow  out  1  bit 0 of the overflow register.
- rsp_err  out  2  00 ok, 01 slave error response, 10 timeout.
- m1_axi_awaddr/awvalid/awready, wdata/wstrb(DATA_WIDTH/8)/wvalid/wready, bresp(2)/bvalid/bready: AXI4-Lite master write channels.
- m1_axi_araddr/arvalid/arready, rdata/rresp(2)/rvalid/rready: AXI4-Lite master read channels.

Function
REQ-003 The FSM SHALL have states IDLE, WA, WB_RESP_A, WB, WB_RESP_B, RR, RR_DATA, RO, RO_DATA, DONE.
REQ-004 In IDLE, cmd_ready SHALL be 1; cmd_valid&cmd_ready SHALL latch opa/opb, clear rsp_err, and go to WA.
REQ-005 Write A (WA) SHALL drive awaddr=BASE_ADDR+0, wdata=opa, wstrb all ones, with awvalid and wvalid both raised in the same cycle.
REQ-006 In WA, awvalid SHALL drop the cycle after awready is sampled with awvalid high, and wvalid SHALL drop the cycle after wready is sampled with wvalid high; these are independent, and either order or simultaneous acceptance is legal.
REQ-007 After both AW and W are accepted, the FSM SHALL raise bready and wait for bvalid (WB_RESP_A).
REQ-008 On the bvalid&bready beat: bresp!=00 SHALL set rsp_err=01 and go to DONE; otherwise go to WB.
REQ-009 WB/WB_RESP_B SHALL repeat REQ-005..008 with address BASE_ADDR+4 and data opb; success SHALL go to RR.
REQ-010 Read result (RR) SHALL drive araddr=BASE_ADDR+8 with arvalid until arready is sampled, then hold rready=1 in RR_DATA until rvalid.
REQ-011 On the RR_DATA beat, rdata SHALL be captured into rsp_result; rresp!=00 SHALL set rsp_err=01 and go to DONE; otherwise go to RO.
REQ-012 RO/RO_DATA SHALL repeat REQ-010 with address BASE_ADDR+12, capturing rdata[0] into rsp_overflow, then go to DONE.
REQ-013 A TIMEOUT-cycle counter SHALL reset on every state entry and on every handshake beat; if it reaches TIMEOUT, all valid/ready outputs SHALL drop, rsp_err SHALL be 10, and the FSM SHALL go to DONE.
REQ-014 DONE SHALL last exactly one cycle with rsp_done=1, then return to IDLE; rsp_result, rsp_overflow and rsp_err SHALL hold until the next accepted command.
REQ-015 No valid output SHALL fall before its ready is sampled, except on timeout; payload signals SHALL be stable while valid is high.
REQ-016 At most one AXI transaction SHALL be outstanding; read and write channels SHALL never be active simultaneously.
REQ-017 cmd_valid outside IDLE SHALL be ignored; operands SHALL not change mid-sequence.
REQ-018 Minimum latency with zero-wait slave (ready high, response the cycle after acceptance) SHALL be: accept to rsp_done = 9 cycles.

Reset
REQ-019 Asserting m1_axi_aresetn low SHALL immediately force IDLE and drive:
- awvalid, wvalid, bready, arvalid, rready, rsp_done: 0.
- Addresses, wdata, wstrb: 0.
- rsp_result, rsp_overflow, rsp_err: 0.
- cmd_ready: 1 after release.
REQ-020 Reset mid-sequence SHALL abandon the transaction without completing any handshake.

Verification
REQ-021 opa=5, opb=7, zero-wait slave returning 12/0 -> write beats at 0x00/0x04, reads at 0x08/0x0C; rsp_result=12, rsp_overflow=0, rsp_err=00; rsp_done 9 cycles after accept.
REQ-022 opa=0xFFFFFFFF, opb=1, slave returns 0 then 1 -> rsp_result=0, rsp_overflow=1.
REQ-023 wready delayed 3 cycles after awready -> awvalid drops after its beat, wvalid holds until wready, no duplicate beats.
REQ-024 bresp=10 on write A -> no write B, rsp_err=01, rsp_done pulse.
REQ-025 TIMEOUT=8, arready never asserted -> arvalid drops after 8 cycles, rsp_err=10, return to IDLE.
REQ-026 Reset asserted in WB_RESP_B -> all valids/readies low asynchronously; after release cmd_ready=1 and a new command completes normally.

Source files
------------

// File: rtl/adder_sequencer.sv
// adder_sequencer: runs one addition on an AXI4-Lite adder peripheral.
// The sequence is write A, write B, read result, then read overflow.
// Only one transaction is in flight at a time, and every wait is bounded
// by a down-counting timeout.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for cmd_valid
// WA         | AW/W of operand A at BASE+0, channels retire independently
// WB_RESP_A  | bready high, waiting for write-A response
// WB         | AW/W of operand B at BASE+4
// WB_RESP_B  | bready high, waiting for write-B response
// RR         | AR of result register at BASE+8
// RR_DATA    | rready high, capture sum
// RO         | AR of overflow register at BASE+12
// RO_DATA    | rready high, capture overflow bit 0
// DONE       | single-cycle rsp_done pulse
module adder_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int TIMEOUT = 255
) (
   input  logic                    m1_axi_aclk,
   input  logic                    m1_axi_aresetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [DATA_WIDTH-1:0]   cmd_opa,
   input  logic [DATA_WIDTH-1:0]   cmd_opb,
   output logic                    rsp_done,
   output logic [DATA_WIDTH-1:0]   rsp_result,
   output logic                    rsp_overflow,
   output logic [1:0]              rsp_err,
   output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
   output logic                    m1_axi_awvalid,
   input  logic                    m1_axi_awready,
   output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
   output logic                    m1_axi_wvalid,
   input  logic                    m1_axi_wready,
   input  logic [1:0]              m1_axi_bresp,
   input  logic                    m1_axi_bvalid,
   output logic                    m1_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
   output logic                    m1_axi_arvalid,
   input  logic                    m1_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
   input  logic [1:0]              m1_axi_rresp,
   input  logic                    m1_axi_rvalid,
   output logic                    m1_axi_rready
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);

   typedef enum logic [3:0] {
      ST_IDLE, ST_WA, ST_WB_RESP_A, ST_WB, ST_WB_RESP_B,
      ST_RR, ST_RR_DATA, ST_RO, ST_RO_DATA, ST_DONE
   } state_t;

   state_t state, state_nxt;
   logic aw_done, w_done;
   logic [DATA_WIDTH-1:0] opa_q, opb_q;
   logic [CNT_W-1:0] cnt;
   logic aw_beat, w_beat, b_beat, ar_beat, r_beat, any_beat;
   logic waiting, timed_out;

   assign aw_beat  = m1_axi_awvalid & m1_axi_awready;
   assign w_beat   = m1_axi_wvalid & m1_axi_wready;
   assign b_beat   = m1_axi_bvalid & m1_axi_bready;
   assign ar_beat  = m1_axi_arvalid & m1_axi_arready;
   assign r_beat   = m1_axi_rvalid & m1_axi_rready;
   assign any_beat = aw_beat | w_beat | b_beat | ar_beat | r_beat;
   assign waiting  = (state != ST_IDLE) && (state != ST_DONE);
   // A beat on the terminal-count cycle still wins over the timeout.
   assign timed_out = waiting && !any_beat && (cnt == CNT_W'(1));

   // State register.
   always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
      if (!m1_axi_aresetn) state <= ST_IDLE;
      else                 state <= state_nxt;
   end

   // Next-state decode; a timeout overrides any other move to DONE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (cmd_valid) state_nxt = ST_WA;
         ST_WA:        if ((aw_done | aw_beat) && (w_done | w_beat)) state_nxt = ST_WB_RESP_A;
         ST_WB_RESP_A: if (b_beat) state_nxt = (m1_axi_bresp != 2'b00) ? ST_DONE : ST_WB;
         ST_WB:        if ((aw_done | aw_beat) && (w_done | w_beat)) state_nxt = ST_WB_RESP_B;
         ST_WB_RESP_B: if (b_beat) state_nxt = (m1_axi_bresp != 2'b00) ? ST_DONE : ST_RR;
         ST_RR:        if (ar_beat) state_nxt = ST_RR_DATA;
         ST_RR_DATA:   if (r_beat) state_nxt = (m1_axi_rresp != 2'b00) ? ST_DONE : ST_RO;
         ST_RO:        if (ar_beat) state_nxt = ST_RO_DATA;
         ST_RO_DATA:   if (r_beat) state_nxt = ST_DONE;
         ST_DONE:      state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
      if (timed_out) state_nxt = ST_DONE;
   end

   // Channel outputs; valids are pure state decode so they fall together on timeout or reset.
   always_comb begin
      cmd_ready      = 1'b0;
      rsp_done       = 1'b0;
      m1_axi_awaddr  = '0;
      m1_axi_awvalid = 1'b0;
      m1_axi_wdata   = '0;
      m1_axi_wstrb   = '0;
      m1_axi_wvalid  = 1'b0;
      m1_axi_bready  = 1'b0;
      m1_axi_araddr  = '0;
      m1_axi_arvalid = 1'b0;
      m1_axi_rready  = 1'b0;
      case (state)
         ST_IDLE: cmd_ready = 1'b1;
         ST_WA: begin
            m1_axi_awaddr  = BASE_ADDR;
            m1_axi_awvalid = !aw_done;
            m1_axi_wdata   = opa_q;
            m1_axi_wstrb   = '1;
            m1_axi_wvalid  = !w_done;
         end
         ST_WB: begin
            m1_axi_awaddr  = BASE_ADDR + ADDR_WIDTH'(4);
            m1_axi_awvalid = !aw_done;
            m1_axi_wdata   = opb_q;
            m1_axi_wstrb   = '1;
            m1_axi_wvalid  = !w_done;
         end
         ST_WB_RESP_A, ST_WB_RESP_B: m1_axi_bready = 1'b1;
         ST_RR: begin
            m1_axi_araddr  = BASE_ADDR + ADDR_WIDTH'(8);
            m1_axi_arvalid = 1'b1;
         end
         ST_RO: begin
            m1_axi_araddr  = BASE_ADDR + ADDR_WIDTH'(12);
            m1_axi_arvalid = 1'b1;
         end
         ST_RR_DATA, ST_RO_DATA: m1_axi_rready = 1'b1;
         ST_DONE: rsp_done = 1'b1;
         default: ;
      endcase
   end

   // Per-channel acceptance flags for the write phases, cleared on every state change.
   always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
      if (!m1_axi_aresetn) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (state_nxt != state) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_beat) aw_done <= 1'b1;
         if (w_beat)  w_done  <= 1'b1;
      end
   end

   // Wait timer: reloads on state entry and on any beat, counts down otherwise.
   always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
      if (!m1_axi_aresetn)                         cnt <= CNT_LOAD;
      else if ((state_nxt != state) || any_beat)   cnt <= CNT_LOAD;
      else if (cnt != '0)                          cnt <= cnt - CNT_W'(1);
   end

   // Operand latch and response registers; the response holds until the next accepted command.
   always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
      if (!m1_axi_aresetn) begin
         opa_q        <= '0;
         opb_q        <= '0;
         rsp_result   <= '0;
         rsp_overflow <= 1'b0;
         rsp_err      <= 2'b00;
      end else begin
         if (state == ST_IDLE && cmd_valid) begin
            opa_q   <= cmd_opa;
            opb_q   <= cmd_opb;
            rsp_err <= 2'b00;
         end
         if (timed_out)                                rsp_err <= 2'b10;
         else if (b_beat && (m1_axi_bresp != 2'b00))   rsp_err <= 2'b01;
         else if (r_beat && (m1_axi_rresp != 2'b00))   rsp_err <= 2'b01;
         if (state == ST_RR_DATA && r_beat) rsp_result   <= m1_axi_rdata;
         if (state == ST_RO_DATA && r_beat) rsp_overflow <= m1_axi_rdata[0];
      end
   end

endmodule

// File: tb/tb_adder_sequencer.sv
// Testbench for adder_sequencer. A behavioural AXI4-Lite adder peripheral
// sits on the master port with per-channel programmable delays. Expected
// values are computed from the operands with plain arithmetic.
module tb_adder_sequencer;
   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          cmd_valid, cmd_ready, rsp_done, rsp_overflow;
   logic [DW-1:0] cmd_opa, cmd_opb, rsp_result;
   logic [1:0]    rsp_err;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   adder_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(8'h00), .TIMEOUT(TMO)) dut (
      .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
      .rsp_done(rsp_done), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
      .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
      .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
      .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
      .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
      .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
   );

   // slave configuration (written by the main sequence)
   int awd = 0, wd = 0, bd = 0, ard = 0, rd = 0;
   bit ar_never = 0, berr_en = 0, allow_drop = 0;
   logic [AW-1:0] berr_addr = '0;

   // slave observations (written by the slave process only)
   logic [AW-1:0] wlog_addr[$];
   logic [DW-1:0] wlog_data[$];
   logic [AW-1:0] rlog_addr[$];
   int proto_err = 0, done_cycles = 0, split_cycles = 0;

   int n_tests = 0, n_fail = 0;

   // Behavioural AXI4-Lite adder peripheral plus protocol monitor, evaluated on falling edges.
   initial begin : slave
      int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
      bit aw_got, w_got, b_pend, b_fire, r_pend, r_fire;
      bit p_awv, p_awb, p_wv, p_wb, p_arv, p_arb;
      logic [AW-1:0] p_awaddr, p_araddr, cur_waddr;
      logic [DW-1:0] p_wdata, cur_wdata, reg_a, reg_b, r_dat;
      logic [1:0] b_rsp;
      logic [DW:0] sum;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0;
      p_awv = 0; p_awb = 0; p_wv = 0; p_wb = 0; p_arv = 0; p_arb = 0;
      p_awaddr = 0; p_araddr = 0; p_wdata = 0; cur_waddr = 0; cur_wdata = 0;
      reg_a = 0; reg_b = 0; r_dat = 0; b_rsp = 0; sum = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; b_pend = 0; b_fire = 0; r_pend = 0; r_fire = 0;
            p_awv = 0; p_awb = 0; p_wv = 0; p_wb = 0; p_arv = 0; p_arb = 0;
            continue;
         end
         // monitor: no valid falls before its beat, payload stable, no read/write overlap
         if (p_awv && !p_awb && !awvalid && !allow_drop) proto_err++;
         if (p_wv && !p_wb && !wvalid && !allow_drop) proto_err++;
         if (p_arv && !p_arb && !arvalid && !allow_drop) proto_err++;
         if (p_awv && !p_awb && awvalid && awaddr !== p_awaddr) proto_err++;
         if (p_wv && !p_wb && wvalid && wdata !== p_wdata) proto_err++;
         if (p_arv && !p_arb && arvalid && araddr !== p_araddr) proto_err++;
         if ((awvalid || wvalid || bready) && (arvalid || rready)) proto_err++;
         if (wvalid && wstrb !== '1) proto_err++;
         if (!awvalid && wvalid) split_cycles++;
         if (rsp_done) done_cycles++;
         // write response
         if (b_fire) begin bvalid = 0; b_fire = 0; end
         if (b_pend) begin
            if (b_cnt >= bd) begin bvalid = 1; bresp = b_rsp; b_pend = 0; end
            else b_cnt++;
         end
         if (bvalid && bready) b_fire = 1;
         // read data
         if (r_fire) begin rvalid = 0; r_fire = 0; end
         if (r_pend) begin
            if (r_cnt >= rd) begin rvalid = 1; rdata = r_dat; rresp = 2'b00; r_pend = 0; end
            else r_cnt++;
         end
         if (rvalid && rready) r_fire = 1;
         // write address
         if (awvalid) begin
            if (aw_got) begin proto_err++; awready = 0; end
            else begin
               awready = (aw_cnt >= awd);
               if (awready) begin aw_got = 1; cur_waddr = awaddr; aw_cnt = 0; end
               else aw_cnt++;
            end
         end else begin awready = 0; aw_cnt = 0; end
         // write data
         if (wvalid) begin
            if (w_got) begin proto_err++; wready = 0; end
            else begin
               wready = (w_cnt >= wd);
               if (wready) begin w_got = 1; cur_wdata = wdata; w_cnt = 0; end
               else w_cnt++;
            end
         end else begin wready = 0; w_cnt = 0; end
         if (aw_got && w_got) begin
            wlog_addr.push_back(cur_waddr);
            wlog_data.push_back(cur_wdata);
            if (cur_waddr == 8'h00) reg_a = cur_wdata;
            if (cur_waddr == 8'h04) reg_b = cur_wdata;
            b_rsp = (berr_en && cur_waddr == berr_addr) ? 2'b10 : 2'b00;
            b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
         end
         // read address
         if (arvalid) begin
            arready = !ar_never && (ar_cnt >= ard);
            if (arready) begin
               rlog_addr.push_back(araddr);
               sum = {1'b0, reg_a} + {1'b0, reg_b};
               if (araddr == 8'h08)      r_dat = sum[DW-1:0];
               else if (araddr == 8'h0C) r_dat = {{(DW-1){1'b0}}, sum[DW]};
               else                      r_dat = '0;
               r_pend = 1; r_cnt = 0; ar_cnt = 0;
            end else ar_cnt++;
         end else begin arready = 0; ar_cnt = 0; end
         p_awv = awvalid; p_awb = awvalid && awready; p_awaddr = awaddr;
         p_wv = wvalid; p_wb = wvalid && wready; p_wdata = wdata;
         p_arv = arvalid; p_arb = arvalid && arready; p_araddr = araddr;
      end
   end

   // snapshots taken by run_cmd for per-command checks
   int wbase, rbase, pe0, dc0, sp0;

   task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
      awd = a; wd = w; bd = b; ard = ar; rd = r;
   endtask

   // Issue one command and wait for rsp_done; cmd inputs are scrambled while busy.
   task automatic run_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output int lat, output bit ok, output int arv);
      wbase = wlog_addr.size(); rbase = rlog_addr.size();
      pe0 = proto_err; dc0 = done_cycles; sp0 = split_cycles;
      @(negedge clk);
      cmd_valid = 1; cmd_opa = a; cmd_opb = b;
      @(negedge clk);
      lat = 1; ok = 0; arv = 0;
      for (int i = 0; i < 200; i++) begin
         if (arvalid) arv++;
         if (rsp_done) begin ok = 1; break; end
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_opa = $urandom; cmd_opb = $urandom;
         @(negedge clk);
         lat++;
      end
      cmd_valid = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      #12;
      n_tests++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_done} !== 6'b0) begin
         n_fail++; $display("FAIL reset_handshakes: got %b expected 000000", {awvalid, wvalid, bready, arvalid, rready, rsp_done});
      end
      n_tests++;
      if (awaddr !== '0 || araddr !== '0 || wdata !== '0 || wstrb !== '0) begin
         n_fail++; $display("FAIL reset_payload: got aw=%0h ar=%0h wd=%0h ws=%0h expected all 0", awaddr, araddr, wdata, wstrb);
      end
      n_tests++;
      if (rsp_result !== '0 || rsp_overflow !== 1'b0 || rsp_err !== 2'b00) begin
         n_fail++; $display("FAIL reset_rsp: got %0h/%0b/%0b expected 0/0/00", rsp_result, rsp_overflow, rsp_err);
      end
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      n_tests++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_basic();
      int lat, arv; bit ok;
      set_delays(0, 0, 0, 0, 0);
      run_cmd(32'd5, 32'd7, lat, ok, arv);
      n_tests++;
      if (!ok || lat !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d (done=%0b) expected 9", lat, ok); end
      n_tests++;
      if (rsp_result !== 32'd12 || rsp_overflow !== 1'b0 || rsp_err !== 2'b00) begin
         n_fail++; $display("FAIL basic_rsp: got %0d/%0b/%0b expected 12/0/00", rsp_result, rsp_overflow, rsp_err);
      end
      n_tests++;
      if (wlog_addr.size() != wbase + 2 || wlog_addr[wbase] !== 8'h00 || wlog_data[wbase] !== 32'd5 ||
          wlog_addr[wbase+1] !== 8'h04 || wlog_data[wbase+1] !== 32'd7) begin
         n_fail++; $display("FAIL basic_writes: got %0d beats expected 2 beats 00:5 04:7", wlog_addr.size() - wbase);
      end
      n_tests++;
      if (rlog_addr.size() != rbase + 2 || rlog_addr[rbase] !== 8'h08 || rlog_addr[rbase+1] !== 8'h0C) begin
         n_fail++; $display("FAIL basic_reads: got %0d beats expected 08,0C", rlog_addr.size() - rbase);
      end
      @(negedge clk);
      n_tests++;
      if (done_cycles - dc0 !== 1 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL basic_done_pulse: got %0d cycles ready=%b expected 1 cycle ready=1", done_cycles - dc0, cmd_ready);
      end
      n_tests++;
      if (proto_err != pe0 || split_cycles != sp0) begin
         n_fail++; $display("FAIL basic_protocol: got %0d errs %0d split expected 0/0", proto_err - pe0, split_cycles - sp0);
      end
   endtask

   task automatic test_overflow();
      int lat, arv; bit ok;
      run_cmd(32'hFFFF_FFFF, 32'd1, lat, ok, arv);
      n_tests++;
      if (!ok || rsp_result !== 32'd0 || rsp_overflow !== 1'b1 || rsp_err !== 2'b00) begin
         n_fail++; $display("FAIL overflow_rsp: got %0h/%0b/%0b expected 0/1/00", rsp_result, rsp_overflow, rsp_err);
      end
   endtask

   task automatic test_wready_delay();
      int lat, arv; bit ok;
      set_delays(0, 3, 0, 0, 0);
      run_cmd(32'h1234, 32'h0100, lat, ok, arv);
      @(negedge clk);
      n_tests++;
      if (!ok || lat !== 15) begin n_fail++; $display("FAIL wdelay_latency: got %0d expected 15", lat); end
      n_tests++;
      if (split_cycles - sp0 !== 6 || proto_err != pe0) begin
         n_fail++; $display("FAIL wdelay_split: got %0d split %0d errs expected 6/0", split_cycles - sp0, proto_err - pe0);
      end
      n_tests++;
      if (wlog_addr.size() != wbase + 2 || rsp_result !== 32'h1334) begin
         n_fail++; $display("FAIL wdelay_beats: got %0d beats result %0h expected 2 / 1334", wlog_addr.size() - wbase, rsp_result);
      end
      set_delays(0, 0, 0, 0, 0);
   endtask

   task automatic test_bresp_err();
      int lat, arv; bit ok;
      berr_en = 1; berr_addr = 8'h00;
      run_cmd(32'd3, 32'd4, lat, ok, arv);
      berr_en = 0;
      n_tests++;
      if (!ok || rsp_err !== 2'b01 || lat !== 3) begin
         n_fail++; $display("FAIL berr_rsp: got err=%b lat=%0d done=%0b expected 01/3/1", rsp_err, lat, ok);
      end
      n_tests++;
      if (wlog_addr.size() != wbase + 1 || rlog_addr.size() != rbase) begin
         n_fail++; $display("FAIL berr_no_more: got %0d writes %0d reads expected 1/0", wlog_addr.size() - wbase, rlog_addr.size() - rbase);
      end
   endtask

   task automatic test_timeout();
      int lat, arv; bit ok;
      ar_never = 1; allow_drop = 1;
      run_cmd(32'd9, 32'd9, lat, ok, arv);
      @(negedge clk);
      ar_never = 0; allow_drop = 0;
      n_tests++;
      if (!ok || arv !== TMO || rsp_err !== 2'b10) begin
         n_fail++; $display("FAIL timeout_ar: got arv=%0d err=%b done=%0b expected %0d/10/1", arv, rsp_err, ok, TMO);
      end
      n_tests++;
      if (cmd_ready !== 1'b1 || arvalid !== 1'b0) begin
         n_fail++; $display("FAIL timeout_idle: got ready=%b arvalid=%b expected 1/0", cmd_ready, arvalid);
      end
   endtask

   task automatic test_reset_mid();
      int lat, arv; bit ok, found;
      logic [DW:0] exp;
      set_delays(0, 0, 5, 0, 0);
      wbase = wlog_addr.size();
      @(negedge clk);
      cmd_valid = 1; cmd_opa = 32'd10; cmd_opb = 32'd20;
      @(negedge clk);
      cmd_valid = 0;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (bready && wlog_addr.size() == wbase + 2) begin found = 1; break; end
         @(negedge clk);
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL rstmid_reach: got no WB_RESP_B expected reached"); end
      #2 rst_n = 0;
      #1;
      n_tests++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_done} !== 6'b0) begin
         n_fail++; $display("FAIL rstmid_async: got %b expected 000000", {awvalid, wvalid, bready, arvalid, rready, rsp_done});
      end
      repeat (2) @(negedge clk);
      rst_n = 1;
      set_delays(0, 0, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (cmd_ready !== 1'b1 || rsp_err !== 2'b00) begin
         n_fail++; $display("FAIL rstmid_idle: got ready=%b err=%b expected 1/00", cmd_ready, rsp_err);
      end
      exp = {1'b0, 32'hDEAD_0000} + {1'b0, 32'h0000_BEEF};
      run_cmd(32'hDEAD_0000, 32'h0000_BEEF, lat, ok, arv);
      n_tests++;
      if (!ok || lat !== 9 || rsp_result !== exp[DW-1:0] || rsp_overflow !== exp[DW] || rsp_err !== 2'b00) begin
         n_fail++; $display("FAIL rstmid_recover: got %0h/%0b/%b lat=%0d expected %0h/%0b/00 lat=9", rsp_result, rsp_overflow, rsp_err, lat, exp[DW-1:0], exp[DW]);
      end
   endtask

   task automatic test_random();
      int lat, arv, exp_lat; bit ok;
      logic [DW-1:0] a, b;
      logic [DW:0] exp;
      for (int i = 0; i < 20; i++) begin
         a = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
         b = (i % 7 == 0) ? 32'h0000_0000 : $urandom;
         set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
         exp = {1'b0, a} + {1'b0, b};
         exp_lat = 9 + 2 * ((awd > wd) ? awd : wd) + 2 * bd + 2 * ard + 2 * rd;
         run_cmd(a, b, lat, ok, arv);
         n_tests++;
         if (!ok || lat !== exp_lat || arv !== 2 + 2 * ard) begin
            n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d arv=%0d expected %0d/%0d", i, lat, arv, exp_lat, 2 + 2 * ard);
         end
         n_tests++;
         if (rsp_result !== exp[DW-1:0] || rsp_overflow !== exp[DW] || rsp_err !== 2'b00) begin
            n_fail++; $display("FAIL rand_rsp[%0d]: got %0h/%0b/%b expected %0h/%0b/00", i, rsp_result, rsp_overflow, rsp_err, exp[DW-1:0], exp[DW]);
         end
         n_tests++;
         if (wlog_addr.size() != wbase + 2 || wlog_data[wbase] !== a || wlog_data[wbase+1] !== b ||
             rlog_addr.size() != rbase + 2 || proto_err != pe0) begin
            n_fail++; $display("FAIL rand_beats[%0d]: got %0d writes %0d reads %0d errs expected 2/2/0", i, wlog_addr.size() - wbase, rlog_addr.size() - rbase, proto_err - pe0);
         end
      end
      set_delays(0, 0, 0, 0, 0);
   endtask

   initial begin
      cmd_valid = 0; cmd_opa = 0; cmd_opb = 0; rst_n = 0;
      test_reset();
      test_basic();
      test_overflow();
      test_wready_delay();
      test_bresp_err();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before 500000");
      $fatal(1, "watchdog expired");
   end
endmodule
